// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: ALU operation codes, RV32I opcodes,
// operand-mux selects and the immediate-format helper used by the decoder.
package alu_issue_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic MUX1_PC  = 1'b0;
    localparam logic MUX1_RS1 = 1'b1;
    localparam logic MUX2_RS2 = 1'b0;
    localparam logic MUX2_IMM = 1'b1;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

    // alt selects SUB/SRA; callers only raise it where the encoding allows.
    function automatic logic [4:0] funct3_alu(input logic [2:0] funct3, input logic alt);
        logic [4:0] code;
        case (funct3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Combinational RV32I decode: instruction word to ALU operation, operand-mux
// selects, 32-bit immediate, destination register and illegal flag.
module rv32i_decode
    import alu_issue_pkg::*;
#(
    parameter int FUNC_WIDTH = 5
) (
    input  logic [31:0]           instr,
    output logic [FUNC_WIDTH-1:0] alu_ctrl,
    output logic                  mux1_ctrl,
    output logic                  mux2_ctrl,
    output logic [31:0]           imm,
    output logic [4:0]            rd_addr,
    output logic                  rd_we,
    output logic                  illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] alu_code;
    logic       writes_rd;
    imm_fmt_e   fmt;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd_addr = instr[11:7];

    always_comb begin
        alu_code  = ALU_ADD;
        mux1_ctrl = MUX1_RS1;
        mux2_ctrl = MUX2_IMM;
        fmt       = IMM_NONE;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                fmt       = IMM_I;
                writes_rd = 1'b1;
                // Shift immediates carry a funct7-style field in imm[11:5].
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    illegal = 1'b1;
                else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    illegal = 1'b1;
                else
                    alu_code = funct3_alu(funct3, instr[30] && funct3 == 3'b101);
            end
            OPC_OP: begin
                mux2_ctrl = MUX2_RS2;
                writes_rd = 1'b1;
                if (funct7 == 7'b0000000)
                    alu_code = funct3_alu(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    alu_code = funct3_alu(funct3, 1'b1);
                else
                    illegal = 1'b1;
            end
            OPC_LUI: begin
                alu_code  = ALU_PASS_B;
                mux1_ctrl = MUX1_PC;
                fmt       = IMM_U;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                mux1_ctrl = MUX1_PC;
                fmt       = IMM_U;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                mux1_ctrl = MUX1_PC;
                fmt       = IMM_J;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                fmt       = IMM_I;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                mux1_ctrl = MUX1_PC;
                fmt       = IMM_B;
            end
            OPC_LOAD: begin
                fmt       = IMM_I;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                fmt = IMM_S;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign imm      = build_imm(instr, fmt);
    assign rd_we    = writes_rd && !illegal && (rd_addr != 5'd0);
    assign alu_ctrl = FUNC_WIDTH'(alu_code);

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: registers operands and decoded control
// behind a valid/ready handshake with flush. ALU_ISSUE_SKID_EN adds a skid entry.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [31:0]           INSTR_IN,
    input  logic [DATA_WIDTH-1:0] PC_IN,
    input  logic [DATA_WIDTH-1:0] RS1_DATA_IN,
    input  logic [DATA_WIDTH-1:0] RS2_DATA_IN,
    input  logic                  FLUSH,
    input  logic                  OUT_READY,
    output logic                  OUT_VALID,
    output logic [DATA_WIDTH-1:0] PC_OUT,
    output logic [DATA_WIDTH-1:0] RS1_OUT,
    output logic [DATA_WIDTH-1:0] RS2_OUT,
    output logic [DATA_WIDTH-1:0] IMM_OUT,
    output logic [FUNC_WIDTH-1:0] ALU_CTRL,
    output logic                  MUX1_CTRL,
    output logic                  MUX2_CTRL,
    output logic [4:0]            RD_ADDR_OUT,
    output logic                  RD_WE_OUT,
    output logic                  ILLEGAL_OUT
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] imm;
        logic [FUNC_WIDTH-1:0] alu_ctrl;
        logic                  mux1;
        logic                  mux2;
        logic [4:0]            rd;
        logic                  rd_we;
        logic                  illegal;
    } bundle_t;

    bundle_t               new_b;
    bundle_t               out_q;
    logic                  out_valid_q;
    logic [FUNC_WIDTH-1:0] dec_alu;
    logic                  dec_mux1;
    logic                  dec_mux2;
    logic [31:0]           dec_imm;
    logic [4:0]            dec_rd;
    logic                  dec_we;
    logic                  dec_illegal;

    rv32i_decode #(
        .FUNC_WIDTH(FUNC_WIDTH)
    ) u_decode (
        .instr    (INSTR_IN),
        .alu_ctrl (dec_alu),
        .mux1_ctrl(dec_mux1),
        .mux2_ctrl(dec_mux2),
        .imm      (dec_imm),
        .rd_addr  (dec_rd),
        .rd_we    (dec_we),
        .illegal  (dec_illegal)
    );

    always_comb begin
        new_b          = '0;
        new_b.pc       = PC_IN;
        new_b.rs1      = RS1_DATA_IN;
        new_b.rs2      = RS2_DATA_IN;
        new_b.imm      = DATA_WIDTH'($signed(dec_imm));
        new_b.alu_ctrl = dec_alu;
        new_b.mux1     = dec_mux1;
        new_b.mux2     = dec_mux2;
        new_b.rd       = dec_rd;
        new_b.rd_we    = dec_we;
        new_b.illegal  = dec_illegal;
    end

`ifdef ALU_ISSUE_SKID_EN
    bundle_t skid_q;
    logic    skid_full;
    logic    in_ready_q;
    logic    out_free;
    logic    accept;

    assign IN_READY = in_ready_q;
    assign out_free = !out_valid_q || OUT_READY;
    assign accept   = IN_VALID && in_ready_q;

    // in_ready_q mirrors !skid_full so IN_READY leaves the block straight from a flop.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            out_valid_q <= 1'b0;
            skid_full   <= 1'b0;
            in_ready_q  <= 1'b1;
            if (RST) begin
                out_q  <= '0;
                skid_q <= '0;
            end
        end else if (out_free) begin
            if (skid_full) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_full   <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                out_valid_q <= accept;
                if (accept)
                    out_q <= new_b;
            end
        end else if (accept) begin
            skid_q     <= new_b;
            skid_full  <= 1'b1;
            in_ready_q <= 1'b0;
        end
    end
`else
    assign IN_READY = !out_valid_q || OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (FLUSH) begin
            out_valid_q <= 1'b0;
        end else if (IN_READY) begin
            out_valid_q <= IN_VALID;
            if (IN_VALID)
                out_q <= new_b;
        end
    end
`endif

    assign OUT_VALID   = out_valid_q;
    assign PC_OUT      = out_q.pc;
    assign RS1_OUT     = out_q.rs1;
    assign RS2_OUT     = out_q.rs2;
    assign IMM_OUT     = out_q.imm;
    assign ALU_CTRL    = out_q.alu_ctrl;
    assign MUX1_CTRL   = out_q.mux1;
    assign MUX2_CTRL   = out_q.mux2;
    assign RD_ADDR_OUT = out_q.rd;
    assign RD_WE_OUT   = out_q.rd_we;
    assign ILLEGAL_OUT = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed RV32I vectors with hand-decoded
// expectations, stall/flush/reset scenarios and an output monitor.
module tb_alu_issue_stage;

    localparam int DW = 32;
    localparam int FW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [31:0]   INSTR_IN;
    logic [DW-1:0] PC_IN;
    logic [DW-1:0] RS1_DATA_IN;
    logic [DW-1:0] RS2_DATA_IN;
    logic          FLUSH;
    logic          OUT_READY;
    logic          OUT_VALID;
    logic [DW-1:0] PC_OUT;
    logic [DW-1:0] RS1_OUT;
    logic [DW-1:0] RS2_OUT;
    logic [DW-1:0] IMM_OUT;
    logic [FW-1:0] ALU_CTRL;
    logic          MUX1_CTRL;
    logic          MUX2_CTRL;
    logic [4:0]    RD_ADDR_OUT;
    logic          RD_WE_OUT;
    logic          ILLEGAL_OUT;

    alu_issue_stage #(.DATA_WIDTH(DW), .FUNC_WIDTH(FW)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR_IN(INSTR_IN), .PC_IN(PC_IN), .RS1_DATA_IN(RS1_DATA_IN),
        .RS2_DATA_IN(RS2_DATA_IN), .FLUSH(FLUSH), .OUT_READY(OUT_READY),
        .OUT_VALID(OUT_VALID), .PC_OUT(PC_OUT), .RS1_OUT(RS1_OUT), .RS2_OUT(RS2_OUT),
        .IMM_OUT(IMM_OUT), .ALU_CTRL(ALU_CTRL), .MUX1_CTRL(MUX1_CTRL),
        .MUX2_CTRL(MUX2_CTRL), .RD_ADDR_OUT(RD_ADDR_OUT), .RD_WE_OUT(RD_WE_OUT),
        .ILLEGAL_OUT(ILLEGAL_OUT)
    );

    always #5 CLK = ~CLK;

    // care: [0] mux1, [1] mux2, [2] imm, [3] rd
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        mux1;
        logic        mux2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [3:0]  care;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_exp;
    logic acc_pend = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [4:0] alu, input logic m1, input logic m2,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic we, input logic ill, input logic [3:0] care);
        exp_t e;
        e = '0;
        e.alu = alu; e.mux1 = m1; e.mux2 = m2; e.imm = imm;
        e.rd = rd; e.we = we; e.ill = ill; e.care = care;
        return e;
    endfunction

    // Input side: record what the DUT accepts (sampled away from the edge).
    always @(negedge CLK) acc_pend = IN_VALID && IN_READY && !FLUSH && !RST;
    always @(posedge CLK) begin
        if (acc_pend) begin
            sb_q.push_back(cur_exp);
            acc_pend = 1'b0;
        end
    end

    // Output side: every transfer out must match the oldest expected bundle.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_unexpected: got bundle pc=0x%08h alu=%0d, expected no transfer",
                         PC_OUT, ALU_CTRL);
            end else begin
                e = sb_q.pop_front();
                check("pc_out", PC_OUT, e.pc);
                check("rs1_out", RS1_OUT, e.rs1);
                check("rs2_out", RS2_OUT, e.rs2);
                check("alu_ctrl", 32'(ALU_CTRL), 32'(e.alu));
                check("rd_we", 32'(RD_WE_OUT), 32'(e.we));
                check("illegal", 32'(ILLEGAL_OUT), 32'(e.ill));
                if (e.care[0]) check("mux1", 32'(MUX1_CTRL), 32'(e.mux1));
                if (e.care[1]) check("mux2", 32'(MUX2_CTRL), 32'(e.mux2));
                if (e.care[2]) check("imm_out", IMM_OUT, e.imm);
                if (e.care[3]) check("rd_addr", 32'(RD_ADDR_OUT), 32'(e.rd));
            end
        end
    end

    task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        exp_t x;
        x = e; x.pc = pc; x.rs1 = rs1; x.rs2 = rs2;
        INSTR_IN = instr; PC_IN = pc; RS1_DATA_IN = rs1; RS2_DATA_IN = rs2;
        cur_exp = x;
        IN_VALID = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        logic accepted;
        accepted = 1'b0;
        present(instr, pc, rs1, rs2, e);
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge CLK);
            if (IN_READY) accepted = 1'b1;
        end
        if (!accepted) begin
            n_checks++;
            $display("FAIL send_accept: IN_READY stayed 0 for instr 0x%08h, expected 1", instr);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    localparam logic [3:0] ALL = 4'b1111;

    initial begin
        logic exp_rdy;
        logic ready_seen;
        logic accepted;
        RST = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
        INSTR_IN = '0; PC_IN = '0; RS1_DATA_IN = '0; RS2_DATA_IN = '0;
        cur_exp = '0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_alu_ctrl", 32'(ALU_CTRL), 32'd0);
        check("rst_imm", IMM_OUT, 32'd0);
        check("rst_pc", PC_OUT, 32'd0);
        check("rst_rd_we", 32'(RD_WE_OUT), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;

        send(32'h00500093, 32'h100, 32'h0, 32'h0, mk(5'd0, 1'b1, 1'b1, 32'd5, 5'd1, 1'b1, 1'b0, ALL));
        @(negedge CLK);
        check("latency_1", 32'(OUT_VALID), 32'd1);
        @(posedge CLK); #1;
        send(32'h402081B3, 32'h104, 32'd9, 32'd4, mk(5'd1, 1'b1, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0, ALL));
        send(32'h123452B7, 32'h108, 32'h0, 32'h0, mk(5'd10, 1'b0, 1'b1, 32'h12345000, 5'd5, 1'b1, 1'b0, 4'b1110));
        send(32'h4030D093, 32'h10C, 32'h80000000, 32'h0, mk(5'd7, 1'b1, 1'b1, 32'h403, 5'd1, 1'b1, 1'b0, ALL));
        send(32'h00000013, 32'h110, 32'h0, 32'h0, mk(5'd0, 1'b1, 1'b1, 32'd0, 5'd0, 1'b0, 1'b0, ALL));
        send(32'h0000000B, 32'h114, 32'h0, 32'h0, mk(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000));
        send(32'h0000028B, 32'h118, 32'h0, 32'h0, mk(5'd0, 1'b0, 1'b0, 32'd0, 5'd5, 1'b0, 1'b1, 4'b1000));
        send(32'h02208233, 32'h11C, 32'd3, 32'd5, mk(5'd0, 1'b0, 1'b0, 32'd0, 5'd4, 1'b0, 1'b1, 4'b1000));
        send(32'hFE208CE3, 32'h120, 32'd1, 32'd1, mk(5'd0, 1'b0, 1'b1, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b0, 4'b0111));
        send(32'h010000EF, 32'h124, 32'h0, 32'h0, mk(5'd0, 1'b0, 1'b1, 32'd16, 5'd1, 1'b1, 1'b0, ALL));
        send(32'hFE20AE23, 32'h128, 32'h1000, 32'h55, mk(5'd0, 1'b1, 1'b1, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 4'b0111));

        // Stall: hold the output for three cycles with the next instruction waiting.
        repeat (3) @(posedge CLK); #1;
        OUT_READY = 1'b0;
        send(32'h00208233, 32'h200, 32'd11, 32'd22, mk(5'd0, 1'b1, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0, ALL));
        present(32'hFFF14313, 32'h204, 32'd7, 32'd8, mk(5'd5, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0, ALL));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            exp_rdy = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
            if (i == 0) exp_rdy = 1'b1;
`endif
            check("stall_valid", 32'(OUT_VALID), 32'd1);
            check("stall_pc", PC_OUT, 32'h200);
            check("stall_rs1", RS1_OUT, 32'd11);
            check("stall_rd", 32'(RD_ADDR_OUT), 32'd4);
            check("stall_in_ready", 32'(IN_READY), 32'(exp_rdy));
            ready_seen = IN_READY;
            @(posedge CLK); #1;
            if (ready_seen) IN_VALID = 1'b0;
        end
        OUT_READY = 1'b1;
        if (IN_VALID) begin
            accepted = 1'b0;
            for (int k = 0; k < 10 && !accepted; k++) begin
                @(negedge CLK);
                if (IN_READY) accepted = 1'b1;
            end
            check("release_accept", 32'(accepted), 32'd1);
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
        end

        // Flush with a held bundle draining and a new instruction presented.
        send(32'h0F00F393, 32'h300, 32'd1, 32'd2, mk(5'd9, 1'b1, 1'b1, 32'hF0, 5'd7, 1'b1, 1'b0, ALL));
        present(32'h00106413, 32'h304, 32'd0, 32'd0, mk(5'd8, 1'b1, 1'b1, 32'd1, 5'd8, 1'b1, 1'b0, ALL));
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        sb_q.delete();
        @(negedge CLK);
        check("flush_valid", 32'(OUT_VALID), 32'd0);
        repeat (2) @(negedge CLK);
        check("flush_no_leak", 32'(OUT_VALID), 32'd0);
        @(posedge CLK); #1;

        // Reset in the middle of a stall.
        OUT_READY = 1'b0;
        send(32'h4030D093, 32'h400, 32'd5, 32'd6, mk(5'd7, 1'b1, 1'b1, 32'h403, 5'd1, 1'b1, 1'b0, ALL));
        @(negedge CLK);
        check("pre_rst_alu", 32'(ALU_CTRL), 32'd7);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        sb_q.delete();
        @(negedge CLK);
        check("midrst_valid", 32'(OUT_VALID), 32'd0);
        check("midrst_alu", 32'(ALU_CTRL), 32'd0);
        check("midrst_imm", IMM_OUT, 32'd0);
        check("midrst_pc", PC_OUT, 32'd0);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        send(32'h00500093, 32'h500, 32'h0, 32'h0, mk(5'd0, 1'b1, 1'b1, 32'd5, 5'd1, 1'b1, 1'b0, ALL));

        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge CLK);
            if (sb_q.size() == 0) accepted = 1'b1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
